// File: rtl/irq_pkg.sv
// Shared types and helpers for the 68000 autovector interrupt controller.
package irq_pkg;

    // Largest supported source count; helper functions work on vectors padded to this width.
    localparam int MAX_SRC = 16;

    typedef enum logic [1:0] {
        IRQ_LEVEL_HI = 2'd0,
        IRQ_RISE     = 2'd1,
        IRQ_FALL     = 2'd2,
        IRQ_BOTH     = 2'd3
    } irq_mode_t;

    // Highest 3-bit level among the active sources. A plain max: ties at the same
    // level need no resolution because only the level is reported, not the source.
    function automatic logic [2:0] max_level(input logic [MAX_SRC-1:0]   act,
                                             input logic [3*MAX_SRC-1:0] lvl);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (act[i] && (lvl[3*i +: 3] > m)) begin
                m = lvl[3*i +: 3];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_src_latch.sv
// One interrupt source: edge detector plus the pending flag it feeds.
module irq_src_latch
    import irq_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  irq_mode_t mode,
    input  logic      src,
    input  logic      en,
    input  logic      set_inh,
    input  logic      clr,
    output logic      pending
);

    logic src_prev_q;
    logic src_prev_d;
    logic pending_q;
    logic pending_d;
    logic rise;
    logic fall;
    logic edge_hit;

    // Next-state: disabled sources drop to 0 and lose any edge seen meanwhile;
    // a fresh edge beats a simultaneous IACK clear; level sources ignore clears.
    always_comb begin
        src_prev_d = src;
        rise       = src & ~src_prev_q;
        fall       = ~src & src_prev_q;
        edge_hit   = 1'b0;
        unique case (mode)
            IRQ_RISE:     edge_hit = rise;
            IRQ_FALL:     edge_hit = fall;
            IRQ_BOTH:     edge_hit = rise | fall;
            IRQ_LEVEL_HI: edge_hit = 1'b0;
            default:      edge_hit = 1'b0;
        endcase
        pending_d = pending_q;
        if (!en || set_inh) begin
            pending_d = 1'b0;
        end else if (mode == IRQ_LEVEL_HI) begin
            pending_d = src;
        end else if (edge_hit) begin
            pending_d = 1'b1;
        end else if (clr) begin
            pending_d = 1'b0;
        end
    end

    // State register; reset loads the live source value so leaving reset is never an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev_q <= src;
            pending_q  <= 1'b0;
        end else begin
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/m68k_irq_ctrl.sv
// 68000 autovector interrupt controller: per-source latches, IACK decode,
// lowest-index-at-level acknowledge, and the registered IPL encoder.
// NUM_SRC is expected in 1..16; SRC_LEVEL of 0 disables a source.
module m68k_irq_ctrl
    import irq_pkg::*;
#(
    parameter int                   NUM_SRC   = 4,
    parameter logic [3*NUM_SRC-1:0] SRC_LEVEL = {3'd7, 3'd6, 3'd5, 3'd4},
    parameter logic [2*NUM_SRC-1:0] SRC_MODE  = {2'd1, 2'd1, 2'd2, 2'd1}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [2:0]         cpu_fc,
    input  logic [2:0]         cpu_addr,
    input  logic               cpu_as_n,
    input  logic               cpu_lds_n,
    output logic [2:0]         ipl_n,
    output logic               vpa_n,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] ack_pulse
);

    logic               iack;
    logic               iack_start;
    logic               iack_prev_q;
    logic               iack_prev_d;
    logic [2:0]         ipl_n_q;
    logic [2:0]         ipl_n_d;
    logic [NUM_SRC-1:0] ack_pulse_q;
    logic [NUM_SRC-1:0] ack_pulse_d;
    logic [NUM_SRC-1:0] ack_sel;
    logic [NUM_SRC-1:0] lvl_on;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] active;
    logic               found;

    // Per-source latches; the level-0 check is constant per instance.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign lvl_on[i] = (SRC_LEVEL[3*i +: 3] != 3'd0);
        assign clr[i]    = iack_start & ack_sel[i];

        irq_src_latch u_latch (
            .clk     (clk),
            .reset   (reset),
            .mode    (irq_mode_t'(SRC_MODE[2*i +: 2])),
            .src     (src[i]),
            .en      (src_en[i]),
            .set_inh (~lvl_on[i]),
            .clr     (clr[i]),
            .pending (pending[i])
        );
    end

    // Bus decode: VPA answers any CPU-space strobe at once; IACK needs the low
    // data strobe too, and only its first clock acts so a held cycle acks once.
    assign vpa_n      = ~((cpu_fc == 3'b111) & ~cpu_as_n);
    assign iack       = (cpu_fc == 3'b111) & ~cpu_as_n & ~cpu_lds_n;
    assign iack_start = iack & ~iack_prev_q;
    assign active     = pending & src_en & lvl_on;

    // Pick the lowest-index pending source at the acknowledged level.
    always_comb begin
        ack_sel = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && pending[i] && lvl_on[i] && (SRC_LEVEL[3*i +: 3] == cpu_addr)) begin
                ack_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Next-state for the IACK history, ack pulse and IPL encoder.
    always_comb begin
        iack_prev_d = iack;
        ack_pulse_d = iack_start ? ack_sel : '0;
        ipl_n_d     = ~max_level(MAX_SRC'(active), (3*MAX_SRC)'(SRC_LEVEL));
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            iack_prev_q <= 1'b0;
            ack_pulse_q <= '0;
            ipl_n_q     <= 3'b111;
        end else begin
            iack_prev_q <= iack_prev_d;
            ack_pulse_q <= ack_pulse_d;
            ipl_n_q     <= ipl_n_d;
        end
    end

    assign ipl_n     = ipl_n_q;
    assign ack_pulse = ack_pulse_q;

endmodule
